// File: rtl/rf_wport_arbiter_if.sv
// Write-port bus: four packed requester channels in, one registered write out.
interface rf_wport_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [3:0]          req_valid;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among four
// writeback requesters; registered write output, pending-write mask, conflict counter.
module rf_wport_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  rf_wport_arbiter_if.slave bus,
  output logic [7:0]        pending_mask,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [ADDR_W-1:0] addr_arr [4];
  logic [DATA_W-1:0] data_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [1:0]        rr_last_q, rr_last_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0] valid_eff;
  logic       grant_any;
  logic [1:0] grant_idx;
  logic       multi_req;

  // Ready is forced low during reset and stall; data/addr never feed the grant.
  assign valid_eff = bus.req_valid & {4{rst_n & ~stall}};
  assign multi_req = ($countones(bus.req_valid) >= 2);

  // Walk from lowest to highest priority so the highest-priority hit wins last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_last_q;
    for (int k = 4; k >= 1; k--) begin
      if (valid_eff[rr_last_q + 2'(k)]) begin
        grant_any = 1'b1;
        grant_idx = rr_last_q + 2'(k);
      end
    end
  end

  assign bus.req_ready = grant_any ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    wr_en_d   = grant_any;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rr_last_d = rr_last_q;
    if (grant_any) begin
      wr_addr_d = addr_arr[grant_idx];
      wr_data_d = data_arr[grant_idx];
      rr_last_d = grant_idx;
    end
    cnt_d = cnt_q;
    if (multi_req && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rr_last_q <= 2'd3;
      cnt_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

  // Registers with a write still in flight: requested now, or being written this cycle.
  always_comb begin
    pending_mask = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_valid[i]) begin
        pending_mask[addr_arr[i]] = 1'b1;
      end
    end
    if (wr_en_q) begin
      pending_mask[wr_addr_q] = 1'b1;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench: reference model + write scoreboard checked every falling
// edge, plus scenario tasks with targeted checks.
module tb_rf_wport_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic [7:0]       pending_mask;
  logic [CNT_W-1:0] conflict_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_wport_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_wport_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .bus          (bus),
    .pending_mask (pending_mask),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  wr_t               w_push;
  wr_t               w_mon;
  logic [1:0]        m_rr      = 2'd3;
  int                m_cnt     = 0;
  logic              exp_wr_en = 1'b0;
  logic [3:0]        held      = 4'b0000;
  logic [ADDR_W-1:0] held_addr [4];
  logic [DATA_W-1:0] held_data [4];
  int                mdl_g;
  int                mon_g;
  logic [3:0]        mon_ready;
  logic [7:0]        mon_mask;

  function automatic int exp_grant(input logic [1:0] last, input logic [3:0] v,
                                   input logic st, input logic rn);
    if (st || !rn) return -1;
    for (int k = 1; k <= 4; k++) begin
      int idx = (int'(last) + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference model: advances on every active edge, resets asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr = 2'd3;
      m_cnt = 0;
      exp_wr_en = 1'b0;
      exp_q.delete();
      held = 4'b0000;
    end else begin
      mdl_g = exp_grant(m_rr, bus.req_valid, stall, rst_n);
      exp_wr_en = (mdl_g >= 0);
      if (mdl_g >= 0) begin
        w_push.addr = bus.req_addr[ADDR_W*mdl_g +: ADDR_W];
        w_push.data = bus.req_data[DATA_W*mdl_g +: DATA_W];
        exp_q.push_back(w_push);
        m_rr = 2'(mdl_g);
      end
      if (($countones(bus.req_valid) >= 2) && (m_cnt < 255)) m_cnt++;
      for (int i = 0; i < 4; i++) begin
        held[i] = bus.req_valid[i] && (mdl_g != i);
        held_addr[i] = bus.req_addr[ADDR_W*i +: ADDR_W];
        held_data[i] = bus.req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always @(negedge clk) begin
    mon_g = exp_grant(m_rr, bus.req_valid, stall, rst_n);
    mon_ready = (mon_g >= 0) ? (4'b0001 << mon_g) : 4'b0000;
    mon_mask = 8'h00;
    for (int i = 0; i < 4; i++)
      if (bus.req_valid[i]) mon_mask[bus.req_addr[ADDR_W*i +: ADDR_W]] = 1'b1;
    n_cmp++;
    if (bus.req_ready !== mon_ready) begin
      n_fail++;
      $display("FAIL sb_ready @%0t: got %b expected %b", $time, bus.req_ready, mon_ready);
    end
    n_cmp++;
    if (bus.wr_en !== exp_wr_en) begin
      n_fail++;
      $display("FAIL sb_wr_en @%0t: got %b expected %b", $time, bus.wr_en, exp_wr_en);
    end
    if (exp_wr_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_queue @%0t: got empty queue expected one write", $time);
      end else begin
        w_mon = exp_q.pop_front();
        mon_mask[w_mon.addr] = 1'b1;
        if ((bus.wr_addr !== w_mon.addr) || (bus.wr_data !== w_mon.data)) begin
          n_fail++;
          $display("FAIL sb_write @%0t: got addr=%0d data=%h expected addr=%0d data=%h",
                   $time, bus.wr_addr, bus.wr_data, w_mon.addr, w_mon.data);
        end else begin
          $display("write @%0t: r%0d <= %h", $time, bus.wr_addr, bus.wr_data);
        end
      end
    end
    n_cmp++;
    if (conflict_cnt !== CNT_W'(m_cnt)) begin
      n_fail++;
      $display("FAIL sb_conflict_cnt @%0t: got %0d expected %0d", $time, conflict_cnt, m_cnt);
    end
    n_cmp++;
    if (pending_mask !== mon_mask) begin
      n_fail++;
      $display("FAIL sb_pending_mask @%0t: got %b expected %b", $time, pending_mask, mon_mask);
    end
    for (int i = 0; i < 4; i++) begin
      if (rst_n && held[i]) begin
        n_cmp++;
        if (!bus.req_valid[i] || (bus.req_addr[ADDR_W*i +: ADDR_W] !== held_addr[i]) ||
            (bus.req_data[DATA_W*i +: DATA_W] !== held_data[i])) begin
          n_fail++;
          $display("FAIL handshake_hold @%0t: requester %0d got valid=%b expected held request",
                   $time, i, bus.req_valid[i]);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_addr[ADDR_W*i +: ADDR_W] = a;
    bus.req_data[DATA_W*i +: DATA_W] = d;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    bus.req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) set_req(i, ADDR_W'(i), DATA_W'(16'hF00 + i));
    bus.req_valid = 4'b1111;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    n_cmp++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
    n_cmp++; if (bus.wr_addr !== 3'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== 16'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0000", bus.wr_data); end
    n_cmp++; if (conflict_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", conflict_cnt); end
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    set_req(0, 3'd5, 16'h1234);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL single_wr_en: got %b expected 1", bus.wr_en); end
    n_cmp++; if (bus.wr_addr !== 3'd5) begin n_fail++; $display("FAIL single_wr_addr: got %0d expected 5", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== 16'h1234) begin n_fail++; $display("FAIL single_wr_data: got %h expected 1234", bus.wr_data); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL single_wr_en_off: got %b expected 0", bus.wr_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, ADDR_W'(i + 1), DATA_W'(16'h1000 + i));
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== (4'b0001 << (c % 4))) begin
        n_fail++; $display("FAIL rr_order c=%0d: got %b expected %b", c, bus.req_ready, 4'b0001 << (c % 4));
      end
      n_cmp++;
      if (conflict_cnt !== CNT_W'(c)) begin
        n_fail++; $display("FAIL rr_cnt c=%0d: got %0d expected %0d", c, conflict_cnt, c);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_same_addr();
    apply_reset();
    set_req(0, 3'd0, 16'h0000);
    bus.req_valid = 4'b0001;
    @(posedge clk); #1 bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    set_req(1, 3'd6, 16'hAAAA);
    set_req(2, 3'd6, 16'h5555);
    bus.req_valid = 4'b0110;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL same_ready1: got %b expected 0010", bus.req_ready); end
    n_cmp++; if (pending_mask[6] !== 1'b1) begin n_fail++; $display("FAIL same_mask1: got %b expected 1", pending_mask[6]); end
    @(posedge clk); #1 bus.req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (bus.wr_data !== 16'hAAAA) begin n_fail++; $display("FAIL same_first: got %h expected aaaa", bus.wr_data); end
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL same_ready2: got %b expected 0100", bus.req_ready); end
    n_cmp++; if (pending_mask[6] !== 1'b1) begin n_fail++; $display("FAIL same_mask2: got %b expected 1", pending_mask[6]); end
    @(posedge clk); #1 bus.req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if ((bus.wr_en !== 1'b1) || (bus.wr_data !== 16'h5555)) begin n_fail++; $display("FAIL same_second: got en=%b data=%h expected en=1 data=5555", bus.wr_en, bus.wr_data); end
    n_cmp++; if (pending_mask[6] !== 1'b1) begin n_fail++; $display("FAIL same_mask3: got %b expected 1", pending_mask[6]); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (pending_mask[6] !== 1'b0) begin n_fail++; $display("FAIL same_mask_clear: got %b expected 0", pending_mask[6]); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, ADDR_W'(i + 1), DATA_W'(16'h2000 + i));
    bus.req_valid = 4'b0001;
    @(posedge clk); #1;
    bus.req_valid = 4'b1111;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready c=%0d: got %b expected 0000", c, bus.req_ready); end
      n_cmp++; if (bus.wr_en !== (c == 0)) begin n_fail++; $display("FAIL stall_wr_en c=%0d: got %b expected %b", c, bus.wr_en, c == 0); end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_resume: got %b expected 0010", bus.req_ready); end
    n_cmp++; if (conflict_cnt !== 8'd3) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 3", conflict_cnt); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (bus.wr_addr !== 3'd2) begin n_fail++; $display("FAIL stall_resume_addr: got %0d expected 2", bus.wr_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict_sat();
    apply_reset();
    set_req(0, 3'd1, 16'h0101);
    set_req(1, 3'd2, 16'h0202);
    bus.req_valid = 4'b0011;
    for (int k = 0; k <= 257; k++) begin
      @(negedge clk);
      if (k >= 253) begin
        n_cmp++;
        if (conflict_cnt !== CNT_W'((k < 255) ? k : 255)) begin
          n_fail++; $display("FAIL sat_cnt k=%0d: got %0d expected %0d", k, conflict_cnt, (k < 255) ? k : 255);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(0, 3'd3, 16'hBEEF);
    set_req(1, 3'd4, 16'h4444);
    bus.req_valid = 4'b0011;
    @(posedge clk); #1 bus.req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if ((bus.wr_en !== 1'b1) || (bus.wr_data !== 16'hBEEF)) begin n_fail++; $display("FAIL mid_pre: got en=%b data=%h expected en=1 data=beef", bus.wr_en, bus.wr_data); end
    n_cmp++; if (conflict_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_pre_cnt: got %0d expected 1", conflict_cnt); end
    #1;
    rst_n = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    n_cmp++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_wr_en: got %b expected 0", bus.wr_en); end
    n_cmp++; if (bus.wr_addr !== 3'd0) begin n_fail++; $display("FAIL mid_wr_addr: got %0d expected 0", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== 16'h0) begin n_fail++; $display("FAIL mid_wr_data: got %h expected 0000", bus.wr_data); end
    n_cmp++; if (conflict_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 0", conflict_cnt); end
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready: got %b expected 0000", bus.req_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first: got %b expected 0001", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_second: got %b expected 0010", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.wr_data !== 16'h4444) begin n_fail++; $display("FAIL mid_pending_kept: got %h expected 4444", bus.wr_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 4'b0000;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_same_addr();
    test_stall();
    test_conflict_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
